// File: rtl/bufferrd_rd_arbiter_pkg.sv
// Shared constants and helpers for the dual-read buffer arbiter.
// Flattened request buses place requester i at bits [i*w +: w].
package bufferrd_rd_arbiter_pkg;

    localparam int NUM_REQ_DEFAULT  = 4;
    localparam int ADDR_LEN_DEFAULT = 6;
    localparam int DATA_LEN_DEFAULT = 32;

    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return r;
    endfunction

    function automatic int slice_lsb(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/bufferrd_rd_arbiter_rr_picker.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping past the top index.
module rr_picker
    import bufferrd_rd_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int PTR_W   = clog2(NUM_REQ_DEFAULT)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt
);

    always_comb begin
        int   idx;
        logic found;
        gnt   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(ptr) + k) % NUM_REQ;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bufferrd_rd_arbiter.sv
// Round-robin sharing of a dual-read buffer among numReq requesters, with
// write-to-read forwarding so each response reflects the grant-cycle write.
module bufferrd_rd_arbiter
    import bufferrd_rd_arbiter_pkg::*;
#(
    parameter int numReq  = NUM_REQ_DEFAULT,
    parameter int addrLen = ADDR_LEN_DEFAULT,
    parameter int dataLen = DATA_LEN_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [numReq-1:0]          req,
    input  logic [numReq*addrLen-1:0]  req_addr0,
    input  logic [numReq*addrLen-1:0]  req_addr1,
    output logic [numReq-1:0]          gnt,
    output logic [numReq-1:0]          rsp_valid,
    output logic [dataLen-1:0]         rsp_data0,
    output logic [dataLen-1:0]         rsp_data1,
    input  logic                       wrt,
    input  logic [addrLen-1:0]         wrt_addr,
    input  logic [dataLen-1:0]         wrt_data,
    output logic                       buf_rd_en,
    output logic [addrLen-1:0]         buf_rd_addr0,
    output logic [addrLen-1:0]         buf_rd_addr1,
    input  logic [dataLen-1:0]         buf_data_out0,
    input  logic [dataLen-1:0]         buf_data_out1
);

    localparam int PTR_W = clog2(numReq);

    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [numReq-1:0]  rsp_valid_q, rsp_valid_d;
    logic               fwd0_q, fwd0_d;
    logic               fwd1_q, fwd1_d;
    logic [dataLen-1:0] wdata_q, wdata_d;
    logic [numReq-1:0]  pick_gnt;
    logic [PTR_W-1:0]   win_idx;
    logic               any_gnt;

    rr_picker #(
        .NUM_REQ (numReq),
        .PTR_W   (PTR_W)
    ) u_rr_picker (
        .req (req),
        .ptr (ptr_q),
        .gnt (pick_gnt)
    );

    // Grants are suppressed while reset is held so no read reaches the buffer.
    assign gnt       = reset ? pick_gnt : '0;
    assign any_gnt   = |gnt;
    assign buf_rd_en = any_gnt;

    always_comb begin
        win_idx      = '0;
        buf_rd_addr0 = '0;
        buf_rd_addr1 = '0;
        for (int i = 0; i < numReq; i++) begin
            if (gnt[i]) begin
                win_idx      = PTR_W'(i);
                buf_rd_addr0 = req_addr0[slice_lsb(i, addrLen) +: addrLen];
                buf_rd_addr1 = req_addr1[slice_lsb(i, addrLen) +: addrLen];
            end
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        rsp_valid_d = gnt;
        fwd0_d      = any_gnt && wrt && (wrt_addr == buf_rd_addr0);
        fwd1_d      = any_gnt && wrt && (wrt_addr == buf_rd_addr1);
        wdata_d     = wdata_q;
        if (any_gnt) begin
            ptr_d   = (win_idx == PTR_W'(numReq - 1)) ? '0 : win_idx + PTR_W'(1);
            wdata_d = wrt_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            rsp_valid_q <= '0;
            fwd0_q      <= 1'b0;
            fwd1_q      <= 1'b0;
            wdata_q     <= '0;
        end else begin
            ptr_q       <= ptr_d;
            rsp_valid_q <= rsp_valid_d;
            fwd0_q      <= fwd0_d;
            fwd1_q      <= fwd1_d;
            wdata_q     <= wdata_d;
        end
    end

    // Data is zeroed outside a response so the ports read 0 straight out of reset.
    assign rsp_valid = rsp_valid_q;
    assign rsp_data0 = (|rsp_valid_q) ? (fwd0_q ? wdata_q : buf_data_out0) : '0;
    assign rsp_data1 = (|rsp_valid_q) ? (fwd1_q ? wdata_q : buf_data_out1) : '0;

endmodule

// File: tb/tb_bufferrd_rd_arbiter.sv
// Bench for bufferrd_rd_arbiter: behavioural buffer, vector table, hand
// sequences for forwarding / wrap / reset, and a randomized phase.
module tb_bufferrd_rd_arbiter;

    localparam int N  = 4;
    localparam int AW = 6;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req;
    logic [N*AW-1:0]   req_addr0, req_addr1;
    logic [N-1:0]      gnt, rsp_valid;
    logic [DW-1:0]     rsp_data0, rsp_data1;
    logic              wrt;
    logic [AW-1:0]     wrt_addr;
    logic [DW-1:0]     wrt_data;
    logic              buf_rd_en;
    logic [AW-1:0]     buf_rd_addr0, buf_rd_addr1;
    logic [DW-1:0]     buf_data_out0, buf_data_out1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bufferrd_rd_arbiter #(.numReq(N), .addrLen(AW), .dataLen(DW)) dut (
        .clk           (clk),
        .reset         (reset),
        .req           (req),
        .req_addr0     (req_addr0),
        .req_addr1     (req_addr1),
        .gnt           (gnt),
        .rsp_valid     (rsp_valid),
        .rsp_data0     (rsp_data0),
        .rsp_data1     (rsp_data1),
        .wrt           (wrt),
        .wrt_addr      (wrt_addr),
        .wrt_data      (wrt_data),
        .buf_rd_en     (buf_rd_en),
        .buf_rd_addr0  (buf_rd_addr0),
        .buf_rd_addr1  (buf_rd_addr1),
        .buf_data_out0 (buf_data_out0),
        .buf_data_out1 (buf_data_out1)
    );

    // Buffer model: synchronous read returning old contents on a same-address write.
    logic          mem_init;
    logic [DW-1:0] mem [64];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int k = 0; k < 64; k++) mem[k] <= '0;
            buf_data_out0 <= '0;
            buf_data_out1 <= '0;
        end else begin
            if (buf_rd_en) begin
                buf_data_out0 <= mem[buf_rd_addr0];
                buf_data_out1 <= mem[buf_rd_addr1];
            end
            if (wrt) mem[wrt_addr] <= wrt_data;
        end
    end

    // Reference model state: pointer and the architectural memory contents.
    int            ptr_m;
    logic [DW-1:0] ref_mem [64];
    logic [N-1:0]  last_eg;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] model_pick(input logic [N-1:0] r, input int p);
        logic [N-1:0] one;
        one = 1;
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return one << ((p + k) % N);
        return '0;
    endfunction

    // One cycle: inputs are already applied after a negedge; ends on the next negedge.
    task automatic step(input bit use_tbl, input logic [N-1:0] tbl_gnt);
        logic [N-1:0]  eg;
        int            w;
        logic [AW-1:0] ea0, ea1;
        logic [DW-1:0] ed0, ed1;
        #1;
        eg = model_pick(req, ptr_m);
        w  = -1;
        for (int k = 0; k < N; k++) if (eg[k]) w = k;
        ea0 = (w >= 0) ? req_addr0[w*AW +: AW] : '0;
        ea1 = (w >= 0) ? req_addr1[w*AW +: AW] : '0;
        chk("gnt", 64'(gnt), 64'(eg));
        if (use_tbl) chk("tbl_gnt", 64'(gnt), 64'(tbl_gnt));
        chk("buf_rd_en", 64'(buf_rd_en), 64'(|eg));
        chk("buf_rd_addr0", 64'(buf_rd_addr0), 64'(ea0));
        chk("buf_rd_addr1", 64'(buf_rd_addr1), 64'(ea1));
        last_eg = eg;
        @(posedge clk);
        if (wrt) ref_mem[wrt_addr] = wrt_data;
        if (w >= 0) ptr_m = (w + 1) % N;
        ed0 = ref_mem[ea0];
        ed1 = ref_mem[ea1];
        @(negedge clk);
        chk("rsp_valid", 64'(rsp_valid), 64'(eg));
        if (eg != '0) begin
            chk("rsp_data0", 64'(rsp_data0), 64'(ed0));
            chk("rsp_data1", 64'(rsp_data1), 64'(ed1));
        end
    endtask

    task automatic set_all(input logic [N-1:0] r, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                           input logic w, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        req = r;
        for (int i = 0; i < N; i++) begin
            req_addr0[i*AW +: AW] = a0;
            req_addr1[i*AW +: AW] = a1;
        end
        wrt = w; wrt_addr = wa; wrt_data = wd;
    endtask

    task automatic write_word(input logic [AW-1:0] a, input logic [DW-1:0] d);
        set_all('0, '0, '0, 1'b1, a, d);
        step(1'b1, '0);
        wrt = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]  req;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic          wrt;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic [N-1:0]  exp_gnt;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [AW-1:0] ra0 [N];
        logic [AW-1:0] ra1 [N];

        // Single requester, then park ptr at 0, fairness x8, then wrap from ptr=3.
        vecs.push_back('{4'b0010, 6'd5, 6'd9, 1'b0, 6'd0, 32'd0, 4'b0010});
        vecs.push_back('{4'b1000, 6'd5, 6'd9, 1'b0, 6'd0, 32'd0, 4'b1000});
        for (int k = 0; k < 8; k++) begin
            logic [N-1:0] g;
            g = 4'b0001 << (k % 4);
            vecs.push_back('{4'b1111, 6'd5, 6'd9, 1'b0, 6'd0, 32'd0, g});
        end
        vecs.push_back('{4'b0100, 6'd9, 6'd5, 1'b0, 6'd0, 32'd0, 4'b0100});
        vecs.push_back('{4'b0101, 6'd5, 6'd5, 1'b0, 6'd0, 32'd0, 4'b0001});
        vecs.push_back('{4'b0101, 6'd9, 6'd9, 1'b0, 6'd0, 32'd0, 4'b0100});

        for (int k = 0; k < 64; k++) ref_mem[k] = '0;
        ptr_m    = 0;
        last_eg  = '0;
        mem_init = 1'b1;
        reset    = 1'b0;
        set_all(4'b1111, 6'd3, 6'd4, 1'b0, '0, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_gnt", 64'(gnt), 64'd0);
        chk("reset_buf_rd_en", 64'(buf_rd_en), 64'd0);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_data0", 64'(rsp_data0), 64'd0);
        chk("reset_rsp_data1", 64'(rsp_data1), 64'd0);
        mem_init = 1'b0;
        set_all('0, '0, '0, 1'b0, '0, '0);
        reset = 1'b1;

        write_word(6'd5, 32'hA);
        write_word(6'd9, 32'hB);

        for (int v = 0; v < vecs.size(); v++) begin
            set_all(vecs[v].req, vecs[v].a0, vecs[v].a1, vecs[v].wrt, vecs[v].wa, vecs[v].wd);
            step(1'b1, vecs[v].exp_gnt);
            if (v == 0) begin
                chk("single_rsp_valid", 64'(rsp_valid), 64'(4'b0010));
                chk("single_rsp_data0", 64'(rsp_data0), 64'hA);
                chk("single_rsp_data1", 64'(rsp_data1), 64'hB);
            end
        end

        // Forwarding: same-address write in the grant cycle on both ports.
        write_word(6'd7, 32'd1);
        set_all(4'b0001, 6'd7, 6'd7, 1'b1, 6'd7, 32'h55);
        step(1'b0, '0);
        chk("fwd_data0", 64'(rsp_data0), 64'h55);
        chk("fwd_data1", 64'(rsp_data1), 64'h55);
        write_word(6'd7, 32'd1);
        set_all(4'b0001, 6'd7, 6'd7, 1'b1, 6'd8, 32'h77);
        step(1'b0, '0);
        chk("nofwd_data0", 64'(rsp_data0), 64'd1);
        chk("nofwd_data1", 64'(rsp_data1), 64'd1);
        // Write to the granted address one cycle after the grant is not seen.
        set_all(4'b0010, 6'd7, 6'd8, 1'b0, '0, '0);
        step(1'b0, '0);
        set_all('0, '0, '0, 1'b1, 6'd7, 32'h99);
        step(1'b1, '0);
        wrt = 1'b0;

        // Randomized traffic; a waiting requester keeps its addresses until granted.
        for (int i = 0; i < N; i++) begin ra0[i] = '0; ra1[i] = '0; end
        req     = '0;
        last_eg = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (req[i] && !last_eg[i]) begin
                    if ($urandom_range(0, 9) == 0) req[i] = 1'b0;
                end else begin
                    req[i] = 1'($urandom_range(0, 1));
                    ra0[i] = AW'($urandom_range(0, 7));
                    ra1[i] = AW'($urandom_range(0, 7));
                end
                req_addr0[i*AW +: AW] = ra0[i];
                req_addr1[i*AW +: AW] = ra1[i];
            end
            wrt      = 1'($urandom_range(0, 1));
            wrt_addr = AW'($urandom_range(0, 7));
            wrt_data = $urandom;
            step(1'b0, '0);
        end

        // Reset mid-flight: a visible grant is dropped and ptr returns to 0.
        set_all(4'b0010, 6'd5, 6'd9, 1'b0, '0, '0);
        step(1'b0, '0);
        set_all(4'b0010, 6'd5, 6'd9, 1'b0, '0, '0);
        #1;
        chk("pre_reset_gnt", 64'(gnt), 64'(model_pick(req, ptr_m)));
        reset = 1'b0;
        #1;
        chk("mid_reset_gnt", 64'(gnt), 64'd0);
        chk("mid_reset_buf_rd_en", 64'(buf_rd_en), 64'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        ptr_m = 0;
        @(negedge clk);
        chk("post_reset_rsp_valid", 64'(rsp_valid), 64'd0);
        set_all(4'b1000, 6'd9, 6'd5, 1'b0, '0, '0);
        step(1'b1, 4'b1000);
        set_all(4'b0000, 6'd0, 6'd0, 1'b0, '0, '0);
        step(1'b1, 4'b0000);
        set_all(4'b1001, 6'd5, 6'd9, 1'b0, '0, '0);
        step(1'b1, 4'b0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bufferrd_rd_arbiter.md
# bufferrd_rd_arbiter

Shares the two read ports of a single dual-read, single-write buffer among `numReq` requesters (PEs or namespace readers) with round-robin arbitration. Each granted request drives both buffer read addresses in one cycle. The returned pair of words is steered back to the winner one cycle later. Read-after-write collisions with the buffer's write port are resolved by forwarding, so every response reflects the write performed in the grant cycle.

## Interface
- `numReq`, 4 — number of requesters, ≥2
- `addrLen`, 6 — buffer address width
- `dataLen`, 32 — buffer word width
- `clk` input 1 — the block's single clock; all state updates on its rising edge
- `reset` input 1 — asynchronous, active-low (0 = reset)
- `req` input numReq — per-requester read request; held with addresses until granted
- `req_addr0` input numReq*addrLen — flattened port-0 addresses, requester i at bits [i*addrLen +: addrLen]
- `req_addr1` input numReq*addrLen — flattened port-1 addresses, same packing
- `gnt` output numReq — one-hot grant, combinational, same cycle as the request
- `rsp_valid` output numReq — one-hot, high one cycle after the grant
- `rsp_data0` output dataLen — port-0 read data, shared by all requesters
- `rsp_data1` output dataLen — port-1 read data, shared by all requesters
- `wrt` input 1 — buffer write enable, observed only
- `wrt_addr` input addrLen — buffer write address, observed only
- `wrt_data` input dataLen — buffer write data, observed only
- `buf_rd_en` output 1 — buffer read enable
- `buf_rd_addr0` output addrLen — buffer port-0 read address
- `buf_rd_addr1` output addrLen — buffer port-1 read address
- `buf_data_out0` input dataLen — buffer port-0 data, valid one cycle after `buf_rd_en`
- `buf_data_out1` input dataLen — buffer port-1 data, valid one cycle after `buf_rd_en`

## Operation
- **Arbitration:** round-robin over `req`, using a registered pointer `ptr` (index width = clog2(numReq)).
  - The winner is the first asserted bit at or after `ptr`, wrapping past numReq-1 to 0.
  - On a grant to i, `ptr` becomes (i+1) mod numReq. With no request, `ptr` holds.
  - At most one grant per cycle. Every persistently requesting input is granted within numReq cycles.
- **Buffer drive:** `buf_rd_en` = OR of `gnt`; `buf_rd_addr0/1` = the winner's addresses. With no grant, the addresses are 0.
- **Response:** the winner's one-hot is registered into `rsp_valid`. `rsp_data0/1` carry `buf_data_out0/1`, or forwarded data (below).
- **Forwarding:** the buffer returns old contents when a read and a write hit the same address in the same cycle. To correct this, in the grant cycle the block registers:
  - `fwd0` = `wrt` && (`wrt_addr` == granted addr0)
  - `fwd1` = `wrt` && (`wrt_addr` == granted addr1)
  - `wrt_data`
- **Response mux:** next cycle, `rsp_data0` = `fwd0` ? registered `wrt_data` : `buf_data_out0`; `rsp_data1` likewise with `fwd1`. Both ports may forward at once when addr0 == addr1.
- A requester must not change its addresses while `req`=1 and `gnt`=0. It may drop `req` at any time before the grant.

## Timing
- **Reset values:** `rsp_valid`=0, `ptr`=0, `fwd0`=`fwd1`=0, forwarded-data register = 0. `rsp_data0/1` follow the mux.
- **Reset asserted mid-operation:** any pending response is discarded; no `rsp_valid` appears after release. `gnt` and `buf_rd_en` are forced to 0 while `reset`=0.
- **Latency:** `gnt` in cycle T; `rsp_valid` and data in T+1. Fully pipelined, with back-to-back grants every cycle.
- **Ports without forwarding:** `rsp_data0/1` when `rsp_valid`=0 are don't-care, except that they are 0 immediately after reset.
- **Writes to the grant address after cycle T:** not forwarded; the response is the T-cycle value.

## Structure
- **Shared package:** constant `NUM_REQ_DEFAULT`, a `clog2` function, and the flattened-bus slice convention.
- **Sub-module `rr_picker`:** combinational round-robin priority selector with inputs `req` and `ptr` and output one-hot `gnt`. It is instantiated once. Pointer update and response logic live in the top.

## Test plan
- **Single requester:** reset, then `req`=0010, addr0=5, addr1=9, buffer preloaded mem[5]=0xA, mem[9]=0xB → `gnt`=0010 at T; `rsp_valid`=0010, `rsp_data0`=0xA, `rsp_data1`=0xB at T+1.
- **Fairness:** all four `req` held for 8 cycles from `ptr`=0 → grant order 0,1,2,3,0,1,2,3, with one `rsp_valid` per cycle lagging by one.
- **Forwarding:** mem[7]=1; grant with addr0=addr1=7 while `wrt`=1, `wrt_addr`=7, `wrt_data`=0x55 → both `rsp_data` = 0x55. A write to addr 8 in the same cycle → `rsp_data` = 1.
- **Wrap:** `ptr`=3, `req`=0101 → `gnt`=0001, then `ptr`=1. Next cycle, `req`=0101 → `gnt`=0100.
- **Reset mid-flight:** drive `reset` low for half a cycle right after a grant → `rsp_valid` stays 0 and `ptr`=0. After release, `req`=1000 is granted on the first edge.
